ram_dp_hs: RTL and testbench

- Parametrised simulation/testbench memory model; next generation of the team's single-port byte-writable RAM model.
- One write port and one read port, both with valid/ready handshakes, plus byte strobes.
- Configurable pipelined read latency, in-order read-response buffer with backpressure, and selectable read-during-write policy.
- Used behind AXI slave bench logic as the backing store for concurrent read/write traffic.

---
 rtl/ram_dp_hs.sv | 160 ++++++++++++++++
 tb/tb_ram_dp_hs.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_hs.sv
// ram_dp_hs: byte-strobed RAM model with a write port, a read port,
// valid/ready handshakes, pipelined read latency and an in-order response buffer.
module ram_dp_hs #(
  parameter int unsigned SZ       = 512,
  parameter int unsigned BW       = 8,
  parameter int unsigned BS       = 4,
  parameter int unsigned WS       = 2,
  parameter int unsigned RQ       = 4,
  parameter int unsigned RDW_MODE = 0,
  parameter int unsigned AW       = $clog2(SZ),
  parameter int unsigned DW       = BW * BS
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          WVALID,
  output logic          WREADY,
  input  logic [AW-1:0] WADDR,
  input  logic [DW-1:0] WDATA,
  input  logic [BS-1:0] WSTRB,
  input  logic          ARVALID,
  output logic          ARREADY,
  input  logic [AW-1:0] ARADDR,
  output logic          RVALID,
  input  logic          RREADY,
  output logic [DW-1:0] RDATA,
  output logic          RERR
);
  localparam int unsigned PW = $clog2(RQ);
  localparam int unsigned OW = $clog2(RQ + 1);

  logic [DW-1:0]         mem [SZ];
  logic                  w_fire_c, ar_fire_c, pop_c;
  logic                  w_in_c, ar_in_c;
  logic [DW-1:0]         rd_word_c;
  logic                  push_c, push_err_c;
  logic [DW-1:0]         push_data_c;
  logic [OW-1:0]         occ_q, occ_d_c;
  logic [OW-1:0]         bcnt_q, bcnt_d_c;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q, wr_ptr_inc_c, rd_ptr_inc_c, head_idx_c;
  logic [RQ-1:0][DW-1:0] fifo_d_q;
  logic [RQ-1:0]         fifo_e_q;
  logic [DW-1:0]         head_d_c;
  logic                  head_e_c;

  assign w_fire_c  = WVALID & WREADY;
  assign ar_fire_c = ARVALID & ARREADY;
  assign pop_c     = RVALID & RREADY;
  assign w_in_c    = ({1'b0, WADDR} < (AW+1)'(SZ));
  assign ar_in_c   = ({1'b0, ARADDR} < (AW+1)'(SZ));

  // Storage: not reset, so contents survive RESETn.
  always_ff @(posedge CLK) begin
    if (w_fire_c && w_in_c)
      for (int unsigned i = 0; i < BS; i++)
        if (WSTRB[i]) mem[WADDR][i*BW +: BW] <= WDATA[i*BW +: BW];
  end

  // Read sample with the read-during-write policy applied.
  always_comb begin
    rd_word_c = '0;
    if (ar_in_c) begin
      rd_word_c = mem[ARADDR];
      if (RDW_MODE != 0 && w_fire_c && WADDR == ARADDR)
        for (int unsigned i = 0; i < BS; i++)
          if (WSTRB[i]) rd_word_c[i*BW +: BW] = WDATA[i*BW +: BW];
    end
  end

  generate
    if (WS > 1) begin : g_pipe
      logic [WS-2:0]         v_q;
      logic [WS-2:0]         e_q;
      logic [WS-2:0][DW-1:0] d_q;

      always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
          v_q <= '0;
          e_q <= '0;
          d_q <= '0;
        end else begin
          v_q[0] <= ar_fire_c;
          e_q[0] <= !ar_in_c;
          d_q[0] <= rd_word_c;
          for (int unsigned i = 1; i < WS - 1; i++) begin
            v_q[i] <= v_q[i-1];
            e_q[i] <= e_q[i-1];
            d_q[i] <= d_q[i-1];
          end
        end
      end

      assign push_c      = v_q[WS-2];
      assign push_err_c  = e_q[WS-2];
      assign push_data_c = d_q[WS-2];
    end else begin : g_nopipe
      assign push_c      = ar_fire_c;
      assign push_err_c  = !ar_in_c;
      assign push_data_c = rd_word_c;
    end
  endgenerate

  assign wr_ptr_inc_c = (wr_ptr_q == PW'(RQ - 1)) ? '0 : PW'(wr_ptr_q + 1'b1);
  assign rd_ptr_inc_c = (rd_ptr_q == PW'(RQ - 1)) ? '0 : PW'(rd_ptr_q + 1'b1);
  assign occ_d_c      = OW'(occ_q + OW'(ar_fire_c) - OW'(pop_c));
  assign bcnt_d_c     = OW'(bcnt_q + OW'(push_c) - OW'(pop_c));

  // Head entry after this edge; bypasses the array when it is being pushed now.
  always_comb begin
    head_idx_c = pop_c ? rd_ptr_inc_c : rd_ptr_q;
    head_d_c   = fifo_d_q[head_idx_c];
    head_e_c   = fifo_e_q[head_idx_c];
    if (push_c && head_idx_c == wr_ptr_q) begin
      head_d_c = push_data_c;
      head_e_c = push_err_c;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      WREADY   <= 1'b0;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
      RDATA    <= '0;
      RERR     <= 1'b0;
      occ_q    <= '0;
      bcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fifo_d_q <= '0;
      fifo_e_q <= '0;
    end else begin
      WREADY  <= 1'b1;
      ARREADY <= (occ_d_c < OW'(RQ));
      occ_q   <= occ_d_c;
      bcnt_q  <= bcnt_d_c;
      if (push_c) begin
        fifo_d_q[wr_ptr_q] <= push_data_c;
        fifo_e_q[wr_ptr_q] <= push_err_c;
        wr_ptr_q           <= wr_ptr_inc_c;
      end
      if (pop_c) rd_ptr_q <= rd_ptr_inc_c;
      RVALID <= (bcnt_d_c != '0);
      if (bcnt_d_c != '0) begin
        RDATA <= head_d_c;
        RERR  <= head_e_c;
      end
    end
  end

  always @(posedge CLK) begin
    if (RESETn) begin
      assert (WS >= 1 && WS <= 8 && RQ >= 2 && RDW_MODE <= 1)
        else $error("ram_dp_hs: parameter out of legal range");
      assert (occ_q <= OW'(RQ))
        else $error("ram_dp_hs: occupancy exceeds RQ");
      assert (!(pop_c && bcnt_q == '0))
        else $error("ram_dp_hs: pop from empty response buffer");
    end
  end
endmodule

// File: tb/tb_ram_dp_hs.sv
// tb_ram_dp_hs: randomized and directed checks of ram_dp_hs (both RDW modes)
// against a queue-based transaction model.
module tb_ram_dp_hs;
  localparam int unsigned SZ = 500;
  localparam int unsigned BW = 8;
  localparam int unsigned BS = 4;
  localparam int unsigned WS = 2;
  localparam int unsigned RQ = 4;
  localparam int unsigned AW = $clog2(SZ);
  localparam int unsigned DW = BW * BS;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          WVALID, ARVALID, RREADY;
  logic [AW-1:0] WADDR, ARADDR;
  logic [DW-1:0] WDATA;
  logic [BS-1:0] WSTRB;
  logic          wready0, arready0, rvalid0, rerr0;
  logic          wready1, arready1, rvalid1, rerr1;
  logic [DW-1:0] rdata0, rdata1;

  always #5 CLK = ~CLK;

  ram_dp_hs #(.SZ(SZ), .BW(BW), .BS(BS), .WS(WS), .RQ(RQ), .RDW_MODE(0)) u0 (
    .CLK(CLK), .RESETn(RESETn), .WVALID(WVALID), .WREADY(wready0), .WADDR(WADDR),
    .WDATA(WDATA), .WSTRB(WSTRB), .ARVALID(ARVALID), .ARREADY(arready0), .ARADDR(ARADDR),
    .RVALID(rvalid0), .RREADY(RREADY), .RDATA(rdata0), .RERR(rerr0));

  ram_dp_hs #(.SZ(SZ), .BW(BW), .BS(BS), .WS(WS), .RQ(RQ), .RDW_MODE(1)) u1 (
    .CLK(CLK), .RESETn(RESETn), .WVALID(WVALID), .WREADY(wready1), .WADDR(WADDR),
    .WDATA(WDATA), .WSTRB(WSTRB), .ARVALID(ARVALID), .ARREADY(arready1), .ARADDR(ARADDR),
    .RVALID(rvalid1), .RREADY(RREADY), .RDATA(rdata1), .RERR(rerr1));

  typedef struct {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          err;
    int            t;
  } rsp_t;

  // Model: outstanding reads in order, each visible from cycle t onwards.
  rsp_t          q[$];
  logic [DW-1:0] m [SZ];
  int            cyc = 0;
  bit            up = 1'b0;
  bit            m_acc = 1'b0;
  bit            e_ar = 1'b0;
  bit            e_rv = 1'b0;
  logic [DW-1:0] last0 = '0;
  logic [DW-1:0] last1 = '0;
  logic          last_err = 1'b0;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic idle();
    WVALID = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
    WADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0;
  endtask

  // One clock: apply the transaction rules to the model, then advance.
  task automatic tick();
    bit wf, af, pf;
    rsp_t r;
    logic [DW-1:0] old, nw;
    wf = up && WVALID;
    af = up && ARVALID && (q.size() < RQ);
    pf = up && RREADY && q.size() > 0 && cyc >= q[0].t;
    if (af) begin
      old = (ARADDR < SZ) ? m[ARADDR] : '0;
      nw  = old;
      if (wf && WADDR == ARADDR)
        for (int unsigned i = 0; i < BS; i++)
          if (WSTRB[i]) nw[i*BW +: BW] = WDATA[i*BW +: BW];
      r.d0  = old;
      r.d1  = (ARADDR < SZ) ? nw : '0;
      r.err = (ARADDR >= SZ);
      r.t   = cyc + int'(WS);
    end
    if (pf) void'(q.pop_front());
    if (af) q.push_back(r);
    if (wf && WADDR < SZ)
      for (int unsigned i = 0; i < BS; i++)
        if (WSTRB[i]) m[WADDR][i*BW +: BW] = WDATA[i*BW +: BW];
    m_acc = af;
    @(posedge CLK);
    #1;
    cyc++;
    up   = RESETn;
    e_ar = up && (q.size() < RQ);
    e_rv = up && q.size() > 0 && cyc >= q[0].t;
    if (e_rv) begin
      last0 = q[0].d0; last1 = q[0].d1; last_err = q[0].err;
    end
  endtask

  task automatic model_reset();
    q.delete(); up = 1'b0; e_ar = 1'b0; e_rv = 1'b0;
    last0 = '0; last1 = '0; last_err = 1'b0;
  endtask

  task automatic wait_rv(output bit ok);
    int k = 0;
    while (rvalid0 !== 1'b1 && k < 20) begin tick(); k++; end
    ok = (rvalid0 === 1'b1);
  endtask

  task automatic drain();
    idle();
    RREADY = 1'b1;
    repeat (WS + RQ + 4) tick();
    RREADY = 1'b0;
  endtask

  task automatic preload();
    for (int a = 0; a < int'(SZ); a++) begin
      WVALID = 1'b1; WADDR = AW'(a); WDATA = DW'($urandom); WSTRB = '1;
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      WVALID = 1'($urandom); ARVALID = 1'($urandom); RREADY = 1'($urandom);
      WADDR = AW'($urandom); ARADDR = AW'($urandom); WDATA = DW'($urandom); WSTRB = BS'($urandom);
      @(posedge CLK); #1; cyc++;
      n_vec++;
      if ({wready0, arready0, rvalid0, rerr0, wready1, arready1, rvalid1, rerr1} !== 8'h00 ||
          rdata0 !== '0 || rdata1 !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: got rdy/vld/err %b%b%b%b %b%b%b%b rdata %h/%h, required all 0",
                 wready0, arready0, rvalid0, rerr0, wready1, arready1, rvalid1, rerr1, rdata0, rdata1);
      end
    end
    idle();
    RESETn = 1'b1;
    n_vec++;
    if (wready0 !== 1'b0 || arready0 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_same_cycle: got WREADY=%b ARREADY=%b, required 0 0", wready0, arready0);
    end
    tick();
    n_vec++;
    if ({wready0, arready0, wready1, arready1} !== 4'hF) begin
      n_err++;
      $display("FAIL reset_first_edge: got WREADY/ARREADY %b%b %b%b, required 11 11",
               wready0, arready0, wready1, arready1);
    end
  endtask

  task automatic test_latency();
    int lat;
    WVALID = 1'b1; WADDR = AW'(5); WDATA = 32'hDEADBEEF; WSTRB = '1;
    tick();
    WVALID = 1'b0;
    ARVALID = 1'b1; ARADDR = AW'(5); RREADY = 1'b1;
    n_vec++;
    if (arready0 !== 1'b1) begin
      n_err++; $display("FAIL lat_arready: got %b, required 1", arready0);
    end
    tick();
    ARVALID = 1'b0;
    lat = 1;
    while (rvalid0 !== 1'b1 && lat < 20) begin tick(); lat++; end
    n_vec++;
    if (lat != int'(WS)) begin
      n_err++; $display("FAIL lat_cycles: got %0d, required %0d", lat, WS);
    end
    n_vec++;
    if (rdata0 !== 32'hDEADBEEF || rerr0 !== 1'b0 || rdata1 !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL lat_data: got %h/%h err %b, required deadbeef err 0", rdata0, rdata1, rerr0);
    end
    tick();
    n_vec++;
    if (rvalid0 !== 1'b0) begin
      n_err++; $display("FAIL lat_single: got RVALID=%b, required 0", rvalid0);
    end
  endtask

  task automatic test_rdw();
    bit ok;
    WVALID = 1'b1; WADDR = AW'(7); WDATA = 32'h11223344; WSTRB = '1;
    tick();
    WDATA = 32'hAABBCCDD; WSTRB = 4'b0101;
    ARVALID = 1'b1; ARADDR = AW'(7); RREADY = 1'b1;
    tick();
    WVALID = 1'b0; ARVALID = 1'b0;
    wait_rv(ok);
    n_vec++;
    if (!ok || rdata0 !== 32'h11223344 || rdata1 !== 32'h11BB33DD) begin
      n_err++;
      $display("FAIL rdw_same_cycle: got vld %b old %h new %h, required 1 11223344 11bb33dd",
               rvalid0, rdata0, rdata1);
    end
    tick();
    ARVALID = 1'b1; ARADDR = AW'(7);
    tick();
    ARVALID = 1'b0;
    wait_rv(ok);
    n_vec++;
    if (!ok || rdata0 !== 32'h11BB33DD || rdata1 !== 32'h11BB33DD) begin
      n_err++;
      $display("FAIL rdw_later_read: got vld %b %h/%h, required 1 11bb33dd", rvalid0, rdata0, rdata1);
    end
  endtask

  task automatic test_backpressure();
    int nxt = 0;
    int got = 0;
    RREADY = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ARVALID = 1'b1; ARADDR = AW'(nxt);
      tick();
      if (m_acc) nxt++;
    end
    n_vec++;
    if (nxt != int'(RQ) || arready0 !== 1'b0 || arready1 !== 1'b0) begin
      n_err++;
      $display("FAIL bp_credit: got %0d accepts ARREADY=%b, required %0d accepts ARREADY=0",
               nxt, arready0, RQ);
    end
    n_vec++;
    if (rvalid0 !== 1'b1 || rdata0 !== m[0]) begin
      n_err++;
      $display("FAIL bp_hold: got vld %b data %h, required 1 %h", rvalid0, rdata0, m[0]);
    end
    RREADY = 1'b1;
    for (int k = 0; k < 60 && got < 10; k++) begin
      ARVALID = (nxt < 10); ARADDR = AW'(nxt);
      if (rvalid0 === 1'b1) begin
        n_vec++;
        if (rdata0 !== m[got] || rerr0 !== 1'b0) begin
          n_err++;
          $display("FAIL bp_order #%0d: got %h err %b, required %h err 0", got, rdata0, rerr0, m[got]);
        end
        got++;
      end
      tick();
      if (m_acc) nxt++;
    end
    ARVALID = 1'b0;
    n_vec++;
    if (got != 10 || nxt != 10) begin
      n_err++; $display("FAIL bp_count: got %0d responses %0d accepts, required 10 10", got, nxt);
    end
    repeat (4) tick();
    n_vec++;
    if (rvalid0 !== 1'b0) begin
      n_err++; $display("FAIL bp_duplicate: got RVALID=%b after drain, required 0", rvalid0);
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    RREADY = 1'b1;
    for (int k = 0; k < 30; k++) begin
      ARVALID = 1'b1; ARADDR = AW'($urandom_range(0, SZ - 1));
      if (arready0 === 1'b1) acc++;
      tick();
      n_vec++;
      if (rvalid0 !== e_rv || rdata0 !== last0) begin
        n_err++;
        $display("FAIL b2b_data: got vld %b %h, required %b %h", rvalid0, rdata0, e_rv, last0);
      end
    end
    ARVALID = 1'b0;
    n_vec++;
    if (acc != 30) begin
      n_err++; $display("FAIL b2b_throughput: got %0d accepts, required 30", acc);
    end
  endtask

  task automatic test_oor();
    bit ok;
    logic [DW-1:0] keep5;
    ARVALID = 1'b1; ARADDR = AW'(505); RREADY = 1'b1;
    tick();
    ARVALID = 1'b0;
    wait_rv(ok);
    n_vec++;
    if (!ok || rdata0 !== '0 || rerr0 !== 1'b1 || rdata1 !== '0 || rerr1 !== 1'b1) begin
      n_err++;
      $display("FAIL oor_read: got vld %b %h err %b, required 1 0 err 1", rvalid0, rdata0, rerr0);
    end
    tick();
    keep5 = m[5];
    WVALID = 1'b1; WADDR = AW'(505); WDATA = DW'($urandom); WSTRB = '1;
    tick();
    WVALID = 1'b0;
    ARVALID = 1'b1; ARADDR = AW'(5);
    tick();
    ARVALID = 1'b0;
    wait_rv(ok);
    n_vec++;
    if (!ok || rdata0 !== keep5 || rerr0 !== 1'b0) begin
      n_err++;
      $display("FAIL oor_alias: got vld %b %h err %b, required 1 %h err 0", rvalid0, rdata0, rerr0, keep5);
    end
  endtask

  task automatic test_reset_midop();
    bit ok;
    RREADY = 1'b0; ARVALID = 1'b1;
    for (int k = 1; k <= 3; k++) begin ARADDR = AW'(k); tick(); end
    ARVALID = 1'b0;
    RESETn = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata0 !== '0 || arready0 !== 1'b0) begin
      n_err++;
      $display("FAIL midop_async: got vld %b/%b rdata %h ARREADY %b, required 0/0 0 0",
               rvalid0, rvalid1, rdata0, arready0);
    end
    @(posedge CLK); #1; cyc++;
    RESETn = 1'b1; RREADY = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      n_vec++;
      if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
        n_err++; $display("FAIL midop_discard: got RVALID %b/%b, required 0/0", rvalid0, rvalid1);
      end
    end
    ARVALID = 1'b1; ARADDR = AW'(5);
    tick();
    ARVALID = 1'b0;
    wait_rv(ok);
    n_vec++;
    if (!ok || rdata0 !== m[5] || rdata0 !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL midop_mem_kept: got vld %b %h, required 1 deadbeef", rvalid0, rdata0);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      WVALID  = 1'($urandom_range(0, 1));
      WADDR   = AW'($urandom_range(0, 511));
      WDATA   = DW'($urandom);
      WSTRB   = BS'($urandom);
      ARVALID = ($urandom_range(0, 9) < 7);
      ARADDR  = ($urandom_range(0, 3) == 0) ? WADDR : AW'($urandom_range(0, 511));
      RREADY  = ($urandom_range(0, 9) < 6);
      tick();
      n_vec++;
      if ({wready0, arready0, rvalid0, wready1, arready1, rvalid1} !== {up, e_ar, e_rv, up, e_ar, e_rv}) begin
        n_err++;
        $display("FAIL rand_hs cyc %0d: got %b, required %b", cyc,
                 {wready0, arready0, rvalid0, wready1, arready1, rvalid1}, {up, e_ar, e_rv, up, e_ar, e_rv});
      end
      n_vec++;
      if (rdata0 !== last0 || rerr0 !== last_err) begin
        n_err++;
        $display("FAIL rand_rdw0 cyc %0d: got %h err %b, required %h err %b", cyc, rdata0, rerr0, last0, last_err);
      end
      n_vec++;
      if (rdata1 !== last1 || rerr1 !== last_err) begin
        n_err++;
        $display("FAIL rand_rdw1 cyc %0d: got %h err %b, required %h err %b", cyc, rdata1, rerr1, last1, last_err);
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    preload();
    test_latency();
    drain();
    test_rdw();
    drain();
    test_backpressure();
    drain();
    test_back_to_back();
    drain();
    test_oor();
    drain();
    test_reset_midop();
    drain();
    test_random();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
